// File: rtl/ps2_host_tx_if.sv
// Command-side bundle of the PS/2 host transmitter: request strobe, byte,
// and the status signals that report the end of each transfer.
interface ps2_host_tx_if;
    // Handshake: wr_ps2 is a valid strobe and tx_idle is its ready. A byte is
    // taken on a cycle where both are high, otherwise wr_ps2 is dropped.
    // tx_ack_ok/tx_err are meaningful only while tx_done_tick is high.
    logic       wr_ps2;
    logic [7:0] din;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_ack_ok;
    logic       tx_err;
    logic [2:0] dbg_state;

    modport master (
        output wr_ps2, din,
        input  tx_idle, tx_done_tick, tx_ack_ok, tx_err, dbg_state
    );

    modport slave (
        input  wr_ps2, din,
        output tx_idle, tx_done_tick, tx_ack_ok, tx_err, dbg_state
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a start bit and
// shifts one odd-parity command byte out on device clock falls, then reads the ack.
module ps2_host_tx #(
    parameter int RTS_CYCLES     = 6000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic         clk,
    input  logic         reset,
    ps2_host_tx_if.slave bus,
    inout  wire          ps2c,
    inout  wire          ps2d
);
    localparam int TMAX = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] RTS_LAST = TW'(RTS_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RTS, S_START, S_DATA, S_STOP, S_ACK, S_DONE
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [3:0]      bit_cnt, bit_cnt_n;
    logic [8:0]      frame, frame_n;
    logic            c_en, c_en_n;
    logic            d_en, d_en_n;
    logic            ack_r, ack_n;
    logic            err_r, err_n;

    logic [FILTER_LEN-1:0] filt_reg, filt_next;
    logic                  filt_c, filt_c_n, filt_c_d, fall_tick;
    logic                  d_s0, d_s1;

    // Level only moves after FILTER_LEN identical samples, so clock glitches are absorbed.
    assign filt_next = {ps2c, filt_reg[FILTER_LEN-1:1]};

    always_comb begin
        filt_c_n = filt_c;
        if (&filt_next)
            filt_c_n = 1'b1;
        else if (~|filt_next)
            filt_c_n = 1'b0;
    end

    assign fall_tick = filt_c_d & ~filt_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_reg <= '1;
            filt_c   <= 1'b1;
            filt_c_d <= 1'b1;
            d_s0     <= 1'b1;
            d_s1     <= 1'b1;
        end else begin
            filt_reg <= filt_next;
            filt_c   <= filt_c_n;
            filt_c_d <= filt_c;
            d_s0     <= ps2d;
            d_s1     <= d_s0;
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        bit_cnt_n = bit_cnt;
        frame_n   = frame;
        c_en_n    = c_en;
        d_en_n    = d_en;
        ack_n     = ack_r;
        err_n     = err_r;
        case (state)
            S_IDLE: begin
                c_en_n = 1'b0;
                d_en_n = 1'b0;
                if (bus.wr_ps2) begin
                    frame_n = {~^bus.din, bus.din};
                    timer_n = '0;
                    ack_n   = 1'b0;
                    err_n   = 1'b0;
                    c_en_n  = 1'b1;
                    state_n = S_RTS;
                end
            end
            S_RTS: begin
                // Our own clock inhibit produces a filtered fall here; it is not acted on.
                if (timer == RTS_LAST) begin
                    c_en_n  = 1'b0;
                    d_en_n  = 1'b1;
                    timer_n = '0;
                    state_n = S_START;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            S_START, S_DATA, S_STOP, S_ACK: begin
                timer_n = timer + TW'(1);
                if (timer == TMO_LAST) begin
                    c_en_n  = 1'b0;
                    d_en_n  = 1'b0;
                    err_n   = 1'b1;
                    ack_n   = 1'b0;
                    state_n = S_DONE;
                end else if (fall_tick) begin
                    case (state)
                        S_START: begin
                            d_en_n    = ~frame[0];
                            frame_n   = {1'b0, frame[8:1]};
                            bit_cnt_n = 4'd8;
                            state_n   = S_DATA;
                        end
                        S_DATA: begin
                            if (bit_cnt == 4'd0) begin
                                d_en_n  = 1'b0;
                                state_n = S_STOP;
                            end else begin
                                d_en_n    = ~frame[0];
                                frame_n   = {1'b0, frame[8:1]};
                                bit_cnt_n = bit_cnt - 4'd1;
                            end
                        end
                        S_STOP: state_n = S_ACK;
                        default: begin
                            ack_n   = ~d_s1;
                            err_n   = 1'b0;
                            state_n = S_DONE;
                        end
                    endcase
                end
            end
            S_DONE: begin
                c_en_n  = 1'b0;
                d_en_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: begin
                c_en_n  = 1'b0;
                d_en_n  = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            frame   <= '0;
            c_en    <= 1'b0;
            d_en    <= 1'b0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_cnt <= bit_cnt_n;
            frame   <= frame_n;
            c_en    <= c_en_n;
            d_en    <= d_en_n;
            ack_r   <= ack_n;
            err_r   <= err_n;
        end
    end

    // Enables are flops, so the open-drain lines never glitch.
    assign ps2c = c_en ? 1'b0 : 1'bz;
    assign ps2d = d_en ? 1'b0 : 1'bz;

    assign bus.tx_idle      = (state == S_IDLE);
    assign bus.tx_done_tick = (state == S_DONE);
    assign bus.tx_ack_ok    = (state == S_DONE) & ack_r;
    assign bus.tx_err       = (state == S_DONE) & err_r;
    assign bus.dbg_state    = state;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the DUT and a
// per-cycle monitor checks handshake, line timing and results against the model.
module tb_ps2_host_tx;
    localparam int RTS = 50;
    localparam int TMO = 1000;
    localparam int FL  = 8;

    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    ps2_host_tx_if bus ();
    wire ps2c;
    wire ps2d;
    pullup (ps2c);
    pullup (ps2d);
    logic dev_c_low = 1'b0;
    logic dev_d_low = 1'b0;
    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;

    ps2_host_tx #(.RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .ps2c  (ps2c),
        .ps2d  (ps2d)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transmission order as the device samples it: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = (($countones(b) % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // ---------------- scoreboard / per-cycle monitor ----------------
    logic [1:0] exp_q[$];        // {err, ack_ok} per accepted transfer
    logic [1:0] e_mon;
    bit mon_en    = 1'b0;
    bit m_idle    = 1'b1;
    int m_since   = 0;
    bit acc_pend  = 1'b0;
    bit done_pend = 1'b0;
    bit rst_pend  = 1'b1;
    bit dev_active = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_pend)       m_idle = 1'b1;
            else if (acc_pend) begin m_idle = 1'b0; m_since = 0; end
            else if (done_pend) m_idle = 1'b1;
            else if (!m_idle)   m_since++;

            check("tx_idle", 32'(bus.tx_idle), 32'(m_idle));
            if (m_idle) begin
                check("done_while_idle", 32'(bus.tx_done_tick), 32'd0);
                if (!dev_c_low && !dev_d_low)
                    check("idle_lines", 32'({ps2c, ps2d}), 32'b11);
            end else begin
                if (m_since < RTS) begin
                    check("rts_c_low", 32'(ps2c), 32'd0);
                    if (!dev_d_low) check("rts_d_high", 32'(ps2d), 32'd1);
                end else if (m_since == RTS && !dev_c_low && !dev_d_low) begin
                    check("release_start", 32'({ps2c, ps2d}), 32'b10);
                end
                if (m_since == RTS + TMO + 1)
                    check("done_by_deadline", 32'(m_since), 32'(RTS + TMO));
                if (bus.tx_done_tick === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("done_no_expect", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e_mon = exp_q.pop_front();
                        check("tx_err", 32'(bus.tx_err), 32'(e_mon[1]));
                        check("tx_ack_ok", 32'(bus.tx_ack_ok), 32'(e_mon[0]));
                        if (e_mon[1]) begin
                            check("timeout_cycle", 32'(m_since), 32'(RTS + TMO));
                            check("timeout_lines", 32'({ps2c, ps2d}), 32'b11);
                        end
                    end
                end
            end
            rst_pend  = reset;
            acc_pend  = bus.wr_ps2 && m_idle && !reset;
            done_pend = (bus.tx_done_tick === 1'b1) && !m_idle;
        end
    end

    // ---------------- device model ----------------
    logic [7:0]  dev_b;
    bit          dev_ack;
    logic [10:0] last_bits;

    task automatic dev_run();
        logic [7:0]  b;
        bit          ack;
        int          hp;
        bit          seen;
        logic [10:0] got;
        b    = dev_b;
        ack  = dev_ack;
        hp   = $urandom_range(15, 30);
        seen = 1'b0;
        got  = '0;
        for (int i = 0; i < RTS + 100 && !seen; i++) begin
            @(negedge clk);
            if (ps2c === 1'b1 && ps2d === 1'b0) seen = 1'b1;
        end
        check("dev_saw_request", 32'(seen), 32'd1);
        if (seen) begin
            repeat ($urandom_range(12, 20)) @(negedge clk);
            for (int i = 0; i < 11; i++) begin
                got[i] = ps2d;
                dev_c_low = 1'b1;
                repeat (hp) @(negedge clk);
                dev_c_low = 1'b0;
                repeat (hp) @(negedge clk);
            end
            last_bits = got;
            check("frame_bits", 32'(got), 32'(frame_bits(b)));
            dev_d_low = ack;
            repeat (hp) @(negedge clk);
            dev_c_low = 1'b1;
            repeat (hp) @(negedge clk);
            dev_c_low = 1'b0;
            dev_d_low = 1'b0;
        end
        dev_active = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_req(input logic [7:0] b);
        @(posedge clk); #1;
        bus.wr_ps2 = 1'b1;
        bus.din    = b;
        @(posedge clk); #1;
        bus.wr_ps2 = 1'b0;
        bus.din    = 8'($urandom);
        check("req_c_low_latency", 32'(ps2c), 32'd0);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < RTS + TMO + 200 && !ok; i++) begin
            @(posedge clk); #1;
            if (bus.tx_done_tick === 1'b1) ok = 1'b1;
        end
        check("wait_done", 32'(ok), 32'd1);
    endtask

    task automatic wait_dev();
        for (int i = 0; i < 500 && dev_active; i++) @(negedge clk);
        check("dev_finished", 32'(dev_active), 32'd0);
    endtask

    // mode 0: device acks, 1: device nacks, 2: device silent (timeout)
    task automatic xfer(input logic [7:0] b, input int mode);
        bit ok;
        exp_q.push_back(mode == 2 ? 2'b10 : (mode == 0 ? 2'b01 : 2'b00));
        start_req(b);
        if (mode != 2) begin
            dev_b      = b;
            dev_ack    = (mode == 0);
            dev_active = 1'b1;
            fork dev_run(); join_none
        end
        wait_done(ok);
        wait_dev();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset      = 1'b1;
        bus.wr_ps2 = 1'b0;
        bus.din    = 8'h00;
        repeat (3) @(posedge clk); #1;
        check("rst_idle", 32'(bus.tx_idle), 32'd1);
        check("rst_done", 32'(bus.tx_done_tick), 32'd0);
        check("rst_ack", 32'(bus.tx_ack_ok), 32'd0);
        check("rst_err", 32'(bus.tx_err), 32'd0);
        check("rst_lines", 32'({ps2c, ps2d}), 32'b11);
        check("rst_state", 32'(bus.dbg_state), 32'd0);
        mon_en = 1'b1;
        reset  = 1'b0;

        // reset in the middle of the clock inhibit drops the transfer
        start_req(8'hA5);
        repeat (19) @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrts_lines", 32'({ps2c, ps2d}), 32'b11);
        check("midrts_idle", 32'(bus.tx_idle), 32'd1);
        reset = 1'b0;
        repeat (FL + 4) @(posedge clk);

        xfer(8'hF4, 0);
        check("frame_f4", 32'(last_bits), 32'b101_1110_1000);
        xfer(8'hFF, 0);
        check("frame_ff", 32'(last_bits), 32'b111_1111_1110);
        xfer(8'h00, 0);
        check("frame_00", 32'(last_bits), 32'b110_0000_0000);
        xfer(8'h5A, 1);
        for (int k = 0; k < 4; k++) xfer(8'($urandom), int'($urandom_range(0, 1)));

        xfer(8'hF4, 2);
        @(posedge clk); #1;
        check("idle_after_timeout", 32'(bus.tx_idle), 32'd1);
        repeat (4) @(posedge clk);

        // requests while busy are dropped; the first idle cycle is honoured
        exp_q.push_back(2'b01);
        start_req(8'h3C);
        dev_b = 8'h3C; dev_ack = 1'b1; dev_active = 1'b1;
        fork dev_run(); join_none
        repeat (RTS + 200) @(posedge clk); #1;
        bus.wr_ps2 = 1'b1;
        bus.din    = 8'h55;
        @(posedge clk); #1;
        bus.wr_ps2 = 1'b0;
        wait_done(ok);
        bus.wr_ps2 = 1'b1;
        bus.din    = 8'h55;
        @(posedge clk); #1;
        bus.din = 8'h96;
        exp_q.push_back(2'b01);
        @(posedge clk); #1;
        bus.wr_ps2 = 1'b0;
        check("accept_first_idle", 32'(ps2c), 32'd0);
        check("accept_busy", 32'(bus.tx_idle), 32'd0);
        wait_dev();
        dev_b = 8'h96; dev_ack = 1'b1; dev_active = 1'b1;
        fork dev_run(); join_none
        wait_done(ok);
        wait_dev();
        check("frame_96", 32'(last_bits), 32'(frame_bits(8'h96)));
        repeat (10) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte (e.g. 0xF4 "enable data reporting", 0xFF reset) from the FPGA to the mouse.
- Sits beside the PS/2 receive path on the same shared open-drain ps2c/ps2d lines.
- The mouse wrapper uses it at start-up, before stream packets are accepted, and releases both lines when idle so the receiver sees the bus untouched.

Parameters:
- RTS_CYCLES, 6000, clock-inhibit hold time in clk cycles (120 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, maximum clk cycles from clock release to ack (15 ms at 50 MHz).
- FILTER_LEN, 8, consecutive equal ps2c samples needed to change the filtered clock level.

Ports:
- clk  input  1  system clock, single clock domain.
- reset  input  1  synchronous, active-high reset.
- wr_ps2  input  1  one-cycle request to send din; honoured only when tx_idle=1.
- din  input  8  command byte, captured on the accepted wr_ps2 cycle.
- ps2c  inout  1  PS/2 clock, open-drain: driven 0 or released (z), never driven 1.
- ps2d  inout  1  PS/2 data, open-drain: driven 0 or released (z), never driven 1.
- tx_idle  output  1  high in idle; the receiver is enabled only while high.
- tx_done_tick  output  1  one-cycle pulse at end of every transfer, including timeout.
- tx_ack_ok  output  1  valid while tx_done_tick=1: device acked (ps2d=0 at ack clock).
- tx_err  output  1  valid while tx_done_tick=1: timeout abort.

Behaviour:
- Reset: state=idle, both line enables off (released), tx_idle=1, tx_done_tick=0, tx_ack_ok=0, tx_err=0, counters 0, filter shift reg all 1s, filtered clock=1.
- Reset mid-transfer: lines released on the next clk edge; the transfer is dropped; no done tick.
- Line drivers: the ps2c/ps2d drive enables come straight from flops, so the lines are glitch-free.
- ps2c filter:
  - FILTER_LEN-bit shift reg samples ps2c every clk.
  - Filtered level goes to 1 when the reg is all 1s, to 0 when all 0s, otherwise holds.
  - fall_tick pulses for one cycle on the filtered 1->0 transition.
- ps2d sampling: two-flop synchronizer before use.
- Frame register: 9-bit {parity, din}; parity = ~^din (odd parity); shifted out LSB first.
- FSM:
  - idle: lines released. On wr_ps2, load the frame, clear the timer, go to rts. Otherwise wr_ps2 is ignored.
  - rts: drive ps2c=0 for RTS_CYCLES. Then drive ps2d=0 (start bit), release ps2c, clear the timeout timer, go to start. Falling edges caused by our own clock drive are ignored.
  - start: hold ps2d=0. On fall_tick: drive ps2d=frame[0], shift the frame right, bit count=8, go to data.
  - data: on fall_tick, if bit count=0, release ps2d (stop bit) and go to stop. Otherwise drive the next frame bit and decrement the count. 9 bits total: 8 data + parity.
  - stop: ps2d released. On fall_tick go to ack.
  - ack: on fall_tick, capture ack_ok = ~ps2d_sync, go to done.
  - done: tx_done_tick=1 with tx_ack_ok and tx_err=0; next cycle idle.
- Timeout: the timer counts in start/data/stop/ack.
  - If it reaches TIMEOUT_CYCLES, release both lines and go to done with tx_err=1, tx_ack_ok=0.
  - Timeout and fall_tick in the same cycle: timeout wins.
- Busy rules:
  - tx_idle=0 from the cycle after an accepted wr_ps2 through the done cycle.
  - wr_ps2 during done is ignored.
  - A new request is accepted the cycle tx_idle returns to 1.
- Latency: ps2c goes low exactly 1 cycle after the accepted wr_ps2. Each fall_tick appears FILTER_LEN cycles after ps2c settles low.

Test Plan:
- Reset mid-rts (RTS_CYCLES=50): assert reset at cycle 20 of rts -> lines released next edge, tx_idle=1, no tx_done_tick.
- din=0xF4, device model clocks at 10 kHz and acks -> ps2c low 6000 cycles; bits at successive device rising edges 0(start),0,0,1,0,1,1,1,1, parity 0, stop 1; tx_done_tick once, tx_ack_ok=1, tx_err=0.
- din=0xFF and din=0x00 -> parity bit 1 for both; frames match the LSB-first bit patterns.
- Device never clocks (TIMEOUT_CYCLES=1000) -> lines released and tx_done_tick with tx_err=1 exactly 1000 cycles after ps2c release; tx_idle=1 next cycle.
- Device acks with ps2d=1 -> tx_done_tick with tx_ack_ok=0, tx_err=0.
- wr_ps2 pulsed during data and during done with din=0x55 -> ignored, original frame unaltered; wr_ps2 on the first idle cycle -> accepted, ps2c low on the following cycle.
